// File: rtl/tmds_encode_multi_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : hdmi_tmds_pkg
//  Description : Shared definitions for the multi-lane TMDS encoder:
//                symbol-mode encodings, control tokens, guard-band words,
//                TERC4 lookup, popcount and 8b/9b transition-minimising
//                helpers, and the lane-count range check.
//  Revision    : 1.0  initial release
// ============================================================================
package hdmi_tmds_pkg;

    // Per-cycle symbol mode, shared by every lane.
    typedef enum logic [1:0] {
        MODE_CTRL  = 2'd0,
        MODE_VIDEO = 2'd1,
        MODE_TERC4 = 2'd2,
        MODE_GUARD = 2'd3
    } tmds_mode_e;

    // Control-period tokens, indexed by {c1,c0}.
    localparam logic [9:0] c_ctrl_tok_00 = 10'b1101010100;
    localparam logic [9:0] c_ctrl_tok_01 = 10'b0010101011;
    localparam logic [9:0] c_ctrl_tok_10 = 10'b0101010100;
    localparam logic [9:0] c_ctrl_tok_11 = 10'b1010101011;

    // Guard-band words.
    localparam logic [9:0] c_gb_even = 10'b1011001100;
    localparam logic [9:0] c_gb_odd  = 10'b0100110011;

    function automatic logic [9:0] ctrl_token(input logic [1:0] c);
        logic [9:0] tok;
        case (c)
            2'b00:   tok = c_ctrl_tok_00;
            2'b01:   tok = c_ctrl_tok_01;
            2'b10:   tok = c_ctrl_tok_10;
            default: tok = c_ctrl_tok_11;
        endcase
        return tok;
    endfunction

    function automatic logic [9:0] terc4_encode(input logic [3:0] nib);
        logic [9:0] sym;
        case (nib)
            4'h0:    sym = 10'b1010011100;
            4'h1:    sym = 10'b1001100011;
            4'h2:    sym = 10'b1011100100;
            4'h3:    sym = 10'b1011100010;
            4'h4:    sym = 10'b0101110001;
            4'h5:    sym = 10'b0100011110;
            4'h6:    sym = 10'b0110001110;
            4'h7:    sym = 10'b0100111100;
            4'h8:    sym = 10'b1011001100;
            4'h9:    sym = 10'b0100111001;
            4'hA:    sym = 10'b0110011100;
            4'hB:    sym = 10'b1011000110;
            4'hC:    sym = 10'b1010001110;
            4'hD:    sym = 10'b1001110001;
            4'hE:    sym = 10'b0101100011;
            default: sym = 10'b1011000011;
        endcase
        return sym;
    endfunction

    function automatic logic [3:0] popcount8(input logic [7:0] v);
        logic [3:0] s;
        s = 4'd0;
        for (int i = 0; i < 8; i++) begin
            s = s + {3'b000, v[i]};
        end
        return s;
    endfunction

    // Transition-minimising stage: chained XOR, or XNOR when the byte is
    // ones-heavy (ties broken by bit 0). Bit 8 records which was used.
    function automatic logic [8:0] qm_encode(input logic [7:0] d, input logic [3:0] n1);
        logic       use_xnor;
        logic [8:0] q;
        use_xnor = (n1 > 4'd4) || ((n1 == 4'd4) && !d[0]);
        q        = 9'd0;
        q[0]     = d[0];
        for (int i = 1; i < 8; i++) begin
            q[i] = use_xnor ? ~(q[i-1] ^ d[i]) : (q[i-1] ^ d[i]);
        end
        q[8] = ~use_xnor;
        return q;
    endfunction

    function automatic bit ch_num_ok(input int n);
        return (n >= 1) && (n <= 4);
    endfunction

endpackage
`default_nettype wire

// File: rtl/tmds_encode_multi_if.sv
`default_nettype none
// ============================================================================
//  Interface   : tmds_encode_multi_if
//  Description : Symbol bus between timing/packet generation and the TMDS
//                encoder. Lane i uses slice i of every vector.
//    mode     [1:0]          symbol mode shared by all lanes
//    gb_type                 guard-band flavour (0 video, 1 data island)
//    ctrl     [2*CH_NUM-1:0] {c1,c0} per lane
//    data_in  [8*CH_NUM-1:0] pixel byte per lane
//    aux_in   [4*CH_NUM-1:0] TERC4 nibble per lane
//    data_out [10*CH_NUM-1:0] encoded symbol per lane
//  Revision    : 1.0  initial release
// ============================================================================
interface tmds_encode_multi_if #(
    parameter int CH_NUM = 3
);
    logic [1:0]           mode;
    logic                 gb_type;
    logic [2*CH_NUM-1:0]  ctrl;
    logic [8*CH_NUM-1:0]  data_in;
    logic [4*CH_NUM-1:0]  aux_in;
    logic [10*CH_NUM-1:0] data_out;

    modport master (
        output mode, gb_type, ctrl, data_in, aux_in,
        input  data_out
    );

    modport slave (
        input  mode, gb_type, ctrl, data_in, aux_in,
        output data_out
    );
endinterface
`default_nettype wire

// File: rtl/tmds_encode_multi_lane.sv
`default_nettype none
// ============================================================================
//  Module      : tmds_encode_lane
//  Description : One TMDS lane, all four symbol modes, three register stages
//                and its own running-disparity counter.
//    vga_clk    pixel clock          sys_rst_n  async active-low reset
//    mode       symbol mode          gb_type    guard-band flavour
//    ctrl       {c1,c0}              data_in    pixel byte
//    aux_in     TERC4 nibble         data_out   10-bit symbol (reset 0)
//  Revision    : 1.0  initial release
// ============================================================================
module tmds_encode_lane
    import hdmi_tmds_pkg::*;
#(
    parameter int LANE_IDX = 0
) (
    input  logic       vga_clk,
    input  logic       sys_rst_n,
    input  logic [1:0] mode,
    input  logic       gb_type,
    input  logic [1:0] ctrl,
    input  logic [7:0] data_in,
    input  logic [3:0] aux_in,
    output logic [9:0] data_out
);

    localparam bit c_lane_even = (LANE_IDX % 2) == 0;
    localparam bit c_lane_zero = (LANE_IDX == 0);

    // ---------------- S1: capture inputs, count ones of the byte -----------
    logic       r1_vld;
    logic [1:0] r1_mode;
    logic       r1_gb;
    logic [1:0] r1_ctrl;
    logic [7:0] r1_data;
    logic [3:0] r1_aux;
    logic [3:0] r1_n1;

    always_ff @(posedge vga_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r1_vld  <= 1'b0;
            r1_mode <= 2'd0;
            r1_gb   <= 1'b0;
            r1_ctrl <= 2'd0;
            r1_data <= 8'd0;
            r1_aux  <= 4'd0;
            r1_n1   <= 4'd0;
        end else begin
            r1_vld  <= 1'b1;
            r1_mode <= mode;
            r1_gb   <= gb_type;
            r1_ctrl <= ctrl;
            r1_data <= data_in;
            r1_aux  <= aux_in;
            r1_n1   <= popcount8(data_in);
        end
    end

    // ---------------- S2: q_m and its ones count ---------------------------
    logic [8:0] w_qm;
    assign w_qm = qm_encode(r1_data, r1_n1);

    logic       r2_vld;
    logic [1:0] r2_mode;
    logic       r2_gb;
    logic [1:0] r2_ctrl;
    logic [3:0] r2_aux;
    logic [8:0] r2_qm;
    logic [3:0] r2_n1;

    always_ff @(posedge vga_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r2_vld  <= 1'b0;
            r2_mode <= 2'd0;
            r2_gb   <= 1'b0;
            r2_ctrl <= 2'd0;
            r2_aux  <= 4'd0;
            r2_qm   <= 9'd0;
            r2_n1   <= 4'd0;
        end else begin
            r2_vld  <= r1_vld;
            r2_mode <= r1_mode;
            r2_gb   <= r1_gb;
            r2_ctrl <= r1_ctrl;
            r2_aux  <= r1_aux;
            r2_qm   <= w_qm;
            r2_n1   <= popcount8(w_qm[7:0]);
        end
    end

    // ---------------- S3: symbol select and DC balance ---------------------
    logic [4:0] r_cnt;      // running disparity, 5-bit two's complement
    logic [4:0] w_n1;
    logic [4:0] w_n0;
    logic [4:0] w_two_q8;   // 2*q_m[8]
    logic [4:0] w_two_nq8;  // 2*~q_m[8]
    logic       w_q8;
    logic       w_cnt_zero;
    logic       w_cnt_neg;
    logic [9:0] w_sym;
    logic [4:0] w_cnt_next;

    assign w_q8       = r2_qm[8];
    assign w_n1       = {1'b0, r2_n1};
    assign w_n0       = 5'd8 - w_n1;
    assign w_two_q8   = {3'b000, w_q8, 1'b0};
    assign w_two_nq8  = {3'b000, ~w_q8, 1'b0};
    assign w_cnt_zero = (r_cnt == 5'd0);
    assign w_cnt_neg  = r_cnt[4];

    always_comb begin
        w_sym      = 10'd0;
        w_cnt_next = 5'd0;   // every non-video symbol restarts the disparity
        case (r2_mode)
            MODE_VIDEO: begin
                if (w_cnt_zero || (w_n1 == w_n0)) begin
                    w_sym      = {~w_q8, w_q8, w_q8 ? r2_qm[7:0] : ~r2_qm[7:0]};
                    w_cnt_next = w_q8 ? (r_cnt + w_n1 - w_n0) : (r_cnt + w_n0 - w_n1);
                end else if ((!w_cnt_neg && (w_n1 > w_n0)) || (w_cnt_neg && (w_n0 > w_n1))) begin
                    w_sym      = {1'b1, w_q8, ~r2_qm[7:0]};
                    w_cnt_next = r_cnt + w_two_q8 + w_n0 - w_n1;
                end else begin
                    w_sym      = {1'b0, w_q8, r2_qm[7:0]};
                    w_cnt_next = r_cnt - w_two_nq8 + w_n1 - w_n0;
                end
            end
            MODE_TERC4: begin
                w_sym = terc4_encode(r2_aux);
            end
            MODE_GUARD: begin
                if (!r2_gb) begin
                    w_sym = c_lane_even ? c_gb_even : c_gb_odd;
                end else begin
                    // Data-island guard band: lane 0 keeps carrying TERC4
                    // (HSYNC/VSYNC/header) while the other lanes send the GB word.
                    w_sym = c_lane_zero ? terc4_encode(r2_aux) : c_gb_odd;
                end
            end
            default: begin
                w_sym = ctrl_token(r2_ctrl);
            end
        endcase
    end

    // The valid flag keeps data_out at 0 until the first sampled symbol
    // has walked through all stages after reset release.
    always_ff @(posedge vga_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            data_out <= 10'd0;
            r_cnt    <= 5'd0;
        end else if (r2_vld) begin
            data_out <= w_sym;
            r_cnt    <= w_cnt_next;
        end
    end

endmodule
`default_nettype wire

// File: rtl/tmds_encode_multi.sv
`default_nettype none
// ============================================================================
//  Module      : tmds_encode_multi
//  Description : CH_NUM-lane TMDS encoder (control / video / TERC4 / guard
//                band), fixed two-edge latency in every mode.
//    vga_clk    pixel clock
//    sys_rst_n  asynchronous active-low reset
//    bus        tmds_encode_multi_if.slave: mode, gb_type, ctrl, data_in,
//               aux_in in; data_out out (lane i = slice i)
//  Revision    : 1.0  initial release
// ============================================================================
module tmds_encode_multi
    import hdmi_tmds_pkg::*;
#(
    parameter int CH_NUM = 3
) (
    input  logic                 vga_clk,
    input  logic                 sys_rst_n,
    tmds_encode_multi_if.slave   bus
);

    if (!ch_num_ok(CH_NUM)) begin : g_ch_num_check
        $error("tmds_encode_multi: CH_NUM must be in 1..4");
    end

    logic [10*CH_NUM-1:0] w_sym;

    for (genvar i = 0; i < CH_NUM; i++) begin : g_lane
        tmds_encode_lane #(
            .LANE_IDX (i)
        ) u_lane (
            .vga_clk   (vga_clk),
            .sys_rst_n (sys_rst_n),
            .mode      (bus.mode),
            .gb_type   (bus.gb_type),
            .ctrl      (bus.ctrl[2*i +: 2]),
            .data_in   (bus.data_in[8*i +: 8]),
            .aux_in    (bus.aux_in[4*i +: 4]),
            .data_out  (w_sym[10*i +: 10])
        );
    end

    assign bus.data_out = w_sym;

endmodule
`default_nettype wire

// File: tb/tb_tmds_encode_multi.sv
`default_nettype none
// ============================================================================
//  Module      : tb_tmds_encode_multi
//  Description : Self-checking bench for tmds_encode_multi with four lanes:
//                directed vector table, asynchronous mid-stream reset and
//                randomized traffic against a behavioural reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_tmds_encode_multi;

    localparam int c_lanes = 4;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    tmds_encode_multi_if #(.CH_NUM(c_lanes)) bus ();

    tmds_encode_multi #(.CH_NUM(c_lanes)) dut (
        .vga_clk   (clk),
        .sys_rst_n (rst_n),
        .bus       (bus)
    );

    int n_err;
    int n_chk;

    // ---------------- reference model --------------------------------------
    logic [9:0]  terc_tbl [16];
    logic [9:0]  ctrl_tbl [4];
    int          mcnt     [c_lanes];
    logic [39:0] mq [$];
    logic [39:0] exp_model;

    function automatic logic [9:0] model_video(input int lane, input logic [7:0] d);
        int         n1, ones, zeros;
        bit         use_xnor;
        logic [8:0] qm;
        logic [9:0] res;
        n1       = $countones(d);
        use_xnor = (n1 > 4) || (n1 == 4 && d[0] == 1'b0);
        qm       = '0;
        qm[0]    = d[0];
        for (int i = 1; i < 8; i++)
            qm[i] = use_xnor ? ~(qm[i-1] ^ d[i]) : (qm[i-1] ^ d[i]);
        qm[8] = use_xnor ? 1'b0 : 1'b1;
        ones  = $countones(qm[7:0]);
        zeros = 8 - ones;
        if (mcnt[lane] == 0 || ones == zeros) begin
            res = {~qm[8], qm[8], qm[8] ? qm[7:0] : ~qm[7:0]};
            mcnt[lane] += qm[8] ? (ones - zeros) : (zeros - ones);
        end else if ((mcnt[lane] > 0 && ones > zeros) || (mcnt[lane] < 0 && zeros > ones)) begin
            res = {1'b1, qm[8], ~qm[7:0]};
            mcnt[lane] += 2 * int'(qm[8]) + zeros - ones;
        end else begin
            res = {1'b0, qm[8], qm[7:0]};
            mcnt[lane] += -2 * int'(!qm[8]) + ones - zeros;
        end
        return res;
    endfunction

    function automatic logic [9:0] model_sym(input int lane, input logic [1:0] m, input logic gb,
                                             input logic [1:0] c, input logic [7:0] d,
                                             input logic [3:0] a);
        logic [9:0] s;
        if (m == 2'd1) begin
            s = model_video(lane, d);
        end else begin
            mcnt[lane] = 0;
            case (m)
                2'd0:    s = ctrl_tbl[c];
                2'd2:    s = terc_tbl[a];
                default: begin
                    if (gb) s = (lane == 0) ? terc_tbl[a] : 10'b0100110011;
                    else    s = (lane % 2 == 0) ? 10'b1011001100 : 10'b0100110011;
                end
            endcase
        end
        return s;
    endfunction

    task automatic model_reset();
        mq.delete();
        for (int l = 0; l < c_lanes; l++) mcnt[l] = 0;
    endtask

    // One rising edge: feed the model with what the DUT just sampled, then
    // step to #1 after the edge where outputs are compared.
    task automatic tick();
        logic [39:0] v;
        @(posedge clk);
        v = '0;
        for (int l = 0; l < c_lanes; l++)
            v[10*l +: 10] = model_sym(l, bus.mode, bus.gb_type, bus.ctrl[2*l +: 2],
                                      bus.data_in[8*l +: 8], bus.aux_in[4*l +: 4]);
        mq.push_back(v);
        if (mq.size() > 2) exp_model = mq.pop_front();
        else               exp_model = '0;
        #1;
    endtask

    task automatic cmp(input string name, input logic [39:0] exp);
        logic [39:0] act;
        act = bus.data_out;
        for (int l = 0; l < c_lanes; l++) begin
            n_chk++;
            if (act[10*l +: 10] !== exp[10*l +: 10]) begin
                n_err++;
                $display("FAIL %s lane%0d: got %b, want %b", name, l,
                         act[10*l +: 10], exp[10*l +: 10]);
            end
        end
    endtask

    task automatic set_in(input logic [1:0] m, input logic gb, input logic [7:0] c,
                          input logic [31:0] d, input logic [15:0] a);
        bus.mode    = m;
        bus.gb_type = gb;
        bus.ctrl    = c;
        bus.data_in = d;
        bus.aux_in  = a;
    endtask

    task automatic set_random();
        int r;
        r = $urandom_range(0, 7);
        set_in((r < 4) ? 2'd1 : 2'(r - 4), 1'($urandom_range(0, 1)), 8'($urandom),
               32'($urandom), 16'($urandom));
    endtask

    // ---------------- directed vector table --------------------------------
    typedef struct packed {
        logic [1:0]  mode;
        logic        gb;
        logic [7:0]  ctrl;
        logic [31:0] data;
        logic [15:0] aux;
        logic [39:0] exp;   // {lane3, lane2, lane1, lane0}
    } vec_t;

    localparam int c_nvec = 13;
    vec_t tbl [c_nvec];

    initial begin
        terc_tbl = '{10'b1010011100, 10'b1001100011, 10'b1011100100, 10'b1011100010,
                     10'b0101110001, 10'b0100011110, 10'b0110001110, 10'b0100111100,
                     10'b1011001100, 10'b0100111001, 10'b0110011100, 10'b1011000110,
                     10'b1010001110, 10'b1001110001, 10'b0101100011, 10'b1011000011};
        ctrl_tbl = '{10'b1101010100, 10'b0010101011, 10'b0101010100, 10'b1010101011};

        tbl[0]  = '{2'd0, 1'b0, 8'h00, 32'h0, 16'h0, {4{10'b1101010100}}};
        tbl[1]  = '{2'd1, 1'b0, 8'h00, 32'h0, 16'h0, {4{10'b0100000000}}};  // cnt -8
        tbl[2]  = '{2'd1, 1'b0, 8'h00, 32'h0, 16'h0, {4{10'b1111111111}}};  // cnt +2
        tbl[3]  = '{2'd1, 1'b0, 8'h00, 32'h0, 16'h0, {4{10'b0100000000}}};  // cnt -6
        tbl[4]  = '{2'd2, 1'b0, 8'h00, 32'h0, 16'h0000, {4{10'b1010011100}}};
        tbl[5]  = '{2'd2, 1'b0, 8'h00, 32'h0, 16'hFFFF, {4{10'b1011000011}}};
        tbl[6]  = '{2'd3, 1'b1, 8'h00, 32'h0, 16'h000C,
                    {10'b0100110011, 10'b0100110011, 10'b0100110011, 10'b1010001110}};
        tbl[7]  = '{2'd3, 1'b0, 8'h00, 32'h0, 16'h0000,
                    {10'b0100110011, 10'b1011001100, 10'b0100110011, 10'b1011001100}};
        tbl[8]  = '{2'd1, 1'b0, 8'h00, 32'h0, 16'h0, {4{10'b0100000000}}};  // cnt -8
        tbl[9]  = '{2'd0, 1'b0, 8'hE4, 32'h0, 16'h0,
                    {10'b1010101011, 10'b0101010100, 10'b0010101011, 10'b1101010100}};
        tbl[10] = '{2'd1, 1'b0, 8'h00, 32'h0, 16'h0, {4{10'b0100000000}}};  // restarted from 0
        tbl[11] = '{2'd1, 1'b0, 8'h00, 32'h1001FF00, 16'h0,
                    {10'b0111110000, 10'b0111111111, 10'b0011111111, 10'b1111111111}};
        tbl[12] = '{2'd0, 1'b0, 8'h00, 32'h0, 16'h0, {4{10'b1101010100}}};
    end

    // ---------------- test sequence ----------------------------------------
    initial begin
        n_err = 0;
        n_chk = 0;
        exp_model = '0;
        rst_n = 1'b0;
        set_in(2'd0, 1'b0, 8'h00, 32'h0, 16'h0);
        #1;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        cmp("reset_state", 40'd0);

        // Release between edges; the next rising edge is the first sample.
        @(negedge clk);
        rst_n = 1'b1;

        for (int k = 0; k < c_nvec + 2; k++) begin
            if (k < c_nvec)
                set_in(tbl[k].mode, tbl[k].gb, tbl[k].ctrl, tbl[k].data, tbl[k].aux);
            tick();
            if (k < 2) cmp("latency_zero", 40'd0);
            else       cmp($sformatf("vec%0d", k - 2), tbl[k-2].exp);
        end

        // Randomized traffic against the reference model.
        for (int i = 0; i < 300; i++) begin
            set_random();
            tick();
            cmp("rand", exp_model);
        end

        // Reset pulse in the middle of a video stream.
        for (int i = 0; i < 5; i++) begin
            set_in(2'd1, 1'b0, 8'h00, 32'($urandom), 16'h0);
            tick();
            cmp("pre_reset", exp_model);
        end
        #2;
        rst_n = 1'b0;
        #1;
        cmp("async_reset", 40'd0);
        @(posedge clk);
        #1;
        cmp("reset_hold", 40'd0);
        #2;
        rst_n = 1'b1;
        model_reset();

        for (int i = 0; i < 200; i++) begin
            if (i < 3) set_in(2'd1, 1'b0, 8'h00, 32'h0, 16'h0);
            else       set_random();
            tick();
            if (i == 2) cmp("post_reset_first", {4{10'b0100000000}});
            cmp("post_reset", exp_model);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
